// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: 4B/5B code-group constants, receive FSM states and the 5B-to-4B lookup,
// shared with the transmit side.
package pcs_rx_pkg;
    localparam logic [4:0] CODE_I = 5'b11111;
    localparam logic [4:0] CODE_J = 5'b11000;
    localparam logic [4:0] CODE_K = 5'b10001;
    localparam logic [4:0] CODE_T = 5'b01101;
    localparam logic [4:0] CODE_R = 5'b00111;
    localparam logic [4:0] CODE_H = 5'b00100;
    localparam logic [9:0] CODE_JK = {CODE_J, CODE_K};

    typedef enum logic [1:0] {IDLE, DATA, END, BAD} state_t;

    // returns {is_data, nibble}
    function automatic logic [4:0] lookup_5b4b(input logic [4:0] g);
        case (g)
            5'b11110: return 5'h10;
            5'b01001: return 5'h11;
            5'b10100: return 5'h12;
            5'b10101: return 5'h13;
            5'b01010: return 5'h14;
            5'b01011: return 5'h15;
            5'b01110: return 5'h16;
            5'b01111: return 5'h17;
            5'b10010: return 5'h18;
            5'b10011: return 5'h19;
            5'b10110: return 5'h1A;
            5'b10111: return 5'h1B;
            5'b11010: return 5'h1C;
            5'b11011: return 5'h1D;
            5'b11100: return 5'h1E;
            5'b11101: return 5'h1F;
            default:  return 5'h00;
        endcase
    endfunction
endpackage

// File: rtl/pcs_rx_decode.sv
// pcs_5b4b_decode: combinational 5B-to-4B decode of one code group (transmit order, MSB first).
module pcs_5b4b_decode
    import pcs_rx_pkg::*;
(
    input  logic [4:0] grp,
    output logic [3:0] nibble,
    output logic       is_data,
    output logic       is_ctrl
);
    assign {is_data, nibble} = lookup_5b4b(grp);
    assign is_ctrl = grp inside {CODE_I, CODE_J, CODE_K, CODE_T, CODE_R, CODE_H};
endmodule

// File: rtl/pcs_rx.sv
// pcs_rx: 100BASE-X style receive PCS; aligns on J,K, decodes 5B groups to nibbles and
// flags false carrier, taking one or two line bits per cycle.
module pcs_rx
    import pcs_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] nrz,
    input  logic [1:0] nrz_valid,
    output logic       rx_ce,
    output logic [3:0] rx_data,
    output logic       rx_dv,
    output logic       rx_er,
    output logic       false_carrier
);
    state_t     state, st;
    logic [9:0] hist, h;
    logic [2:0] cnt, c;
    logic [4:0] grp;
    logic [3:0] nibble, e_data;
    logic       is_data, is_ctrl, emit, e_dv, e_er, fc, done, b, take;

    // a group needs five bits, so at most one completes per cycle; the registered
    // count tells whether it ends on the first or the second bit
    assign grp = (cnt == 3'd4) ? {hist[3:0], nrz[1]} : {hist[2:0], nrz};

    pcs_5b4b_decode u_dec (
        .grp    (grp),
        .nibble (nibble),
        .is_data(is_data),
        .is_ctrl(is_ctrl)
    );

    always_comb begin
        st = state;
        h = hist;
        c = cnt;
        emit = 1'b0;
        e_dv = 1'b0;
        e_er = 1'b0;
        e_data = 4'h0;
        fc = 1'b0;
        done = 1'b0;
        b = 1'b0;
        take = 1'b0;
        for (int i = 0; i < 2; i++) begin
            take = (i == 0) ? (nrz_valid != 2'b00) : nrz_valid[1];
            b = (i == 0) ? nrz[1] : nrz[0];
            if (take) begin
                h = {h[8:0], b};
                done = (c == 3'd4);
                c = done ? 3'd0 : c + 3'd1;
                case (st)
                    // judge a start delimiter once its first zero sits where J's would
                    IDLE: if (h == CODE_JK) begin
                        st = DATA;
                        c = 3'd0;
                    end else if (!h[7] && |(~h[6:0])) begin
                        st = BAD;
                        fc = 1'b1;
                        emit = 1'b1;
                        e_er = 1'b1;
                        e_data = 4'hE;
                    end
                    DATA: if (done) begin
                        emit = !(is_ctrl && grp == CODE_T);
                        e_dv = !(is_ctrl && grp == CODE_I);
                        e_er = !is_data;
                        e_data = is_data ? nibble : 4'h0;
                        if (!emit) st = END;
                        else if (!e_dv) begin
                            st = IDLE;
                            h = '1;
                        end
                    end
                    END: if (done) begin
                        emit = 1'b1;
                        e_er = !(is_ctrl && grp == CODE_R);
                        st = IDLE;
                        h = '1;
                    end
                    BAD: if (&h) st = IDLE;
                    default: st = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hist <= '1;
            cnt <= '0;
            rx_ce <= 1'b0;
            rx_data <= 4'h0;
            rx_dv <= 1'b0;
            rx_er <= 1'b0;
            false_carrier <= 1'b0;
        end else begin
            state <= st;
            hist <= h;
            cnt <= c;
            rx_ce <= emit && !rx_ce;
            false_carrier <= fc;
            if (emit && !rx_ce) begin
                rx_data <= e_data;
                rx_dv <= e_dv;
                rx_er <= e_er;
            end
        end
    end
endmodule

// File: tb/tb_pcs_rx.sv
// tb_pcs_rx: directed scenarios for pcs_rx with hand-computed nibble sequences.
module tb_pcs_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] nrz = 2'b00;
    logic [1:0] nrz_valid = 2'b00;
    logic       rx_ce, rx_dv, rx_er, false_carrier;
    logic [3:0] rx_data;

    int total = 0, bad = 0, cyc = 0, fc_cnt = 0;
    bit q[$];
    logic [5:0] ev[$];
    int ev_cyc[$];
    bit ev_fc[$];

    localparam logic [4:0] G_I = 5'b11111, G_J = 5'b11000, G_K = 5'b10001;
    localparam logic [4:0] G_T = 5'b01101, G_R = 5'b00111, G_H = 5'b00100;
    localparam logic [4:0] DAT [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                        5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                        5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                        5'b11010, 5'b11011, 5'b11100, 5'b11101};

    pcs_rx dut (
        .clk          (clk),
        .rst          (rst),
        .nrz          (nrz),
        .nrz_valid    (nrz_valid),
        .rx_ce        (rx_ce),
        .rx_data      (rx_data),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .false_carrier(false_carrier)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [4:0] g);
        for (int i = 4; i >= 0; i--) q.push_back(g[i]);
    endtask

    // events are recorded as {dv, er, data}
    task automatic cycle(input logic [1:0] v, input logic [1:0] d);
        nrz_valid = v;
        nrz = d;
        @(posedge clk);
        #1;
        cyc++;
        if (rx_ce) begin
            ev.push_back({rx_dv, rx_er, rx_data});
            ev_cyc.push_back(cyc);
            ev_fc.push_back(false_carrier);
        end
        if (false_carrier) fc_cnt++;
    endtask

    // mode 2: two bits per cycle; mode 1: one bit per cycle with every third cycle stalled
    task automatic run(input int mode);
        int n = 0;
        ev.delete();
        ev_cyc.delete();
        ev_fc.delete();
        cyc = 0;
        fc_cnt = 0;
        while (q.size() > 0) begin
            n++;
            if (mode == 1 && n % 3 == 0) begin
                cycle(2'b00, 2'(n));
                total++;
                if (rx_ce !== 1'b0 || false_carrier !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_quiet cyc=%0d: rx_ce=%b fc=%b, want 0 0", cyc, rx_ce, false_carrier);
                end
            end else if (mode == 2 && q.size() > 1) begin
                cycle(2'b10, {q[0], q[1]});
                void'(q.pop_front());
                void'(q.pop_front());
            end else begin
                cycle(2'b01, {q[0], 1'b0});
                void'(q.pop_front());
            end
        end
        cycle(2'b00, 2'b00);
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({rx_ce, rx_data, rx_dv, rx_er, false_carrier} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got %b, want 00000000", {rx_ce, rx_data, rx_dv, rx_er, false_carrier});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_two_bit;
        logic [5:0] exp [4] = '{{2'b10, 4'h5}, {2'b10, 4'h5}, {2'b10, 4'hD}, {2'b00, 4'h0}};
        push(G_I); push(G_I); push(G_J); push(G_K);
        push(DAT[5]); push(DAT[5]); push(DAT[13]); push(G_T); push(G_R); push(G_I); push(G_I);
        run(2);
        total++;
        if (ev.size() != 4) begin
            bad++;
            $display("FAIL two_bit_count: got %0d events, want 4", ev.size());
        end
        for (int k = 0; k < ev.size() && k < 4; k++) begin
            total++;
            if (exp[k][5] ? ev[k] !== exp[k] : ev[k][5:4] !== exp[k][5:4]) begin
                bad++;
                $display("FAIL two_bit_ev%0d: got %h, want %h", k, ev[k], exp[k]);
            end
        end
        if (ev.size() == 4) begin
            total++;
            if (ev_cyc[0] != 13 || ev_cyc[3] != 23) begin
                bad++;
                $display("FAIL two_bit_latency: got cycles %0d,%0d, want 13,23", ev_cyc[0], ev_cyc[3]);
            end
        end
    endtask

    task automatic test_one_bit_stall;
        logic [5:0] exp [4] = '{{2'b10, 4'h5}, {2'b10, 4'h5}, {2'b10, 4'hD}, {2'b00, 4'h0}};
        int adj = 0;
        push(G_I); push(G_I); push(G_J); push(G_K);
        push(DAT[5]); push(DAT[5]); push(DAT[13]); push(G_T); push(G_R); push(G_I); push(G_I);
        run(1);
        total++;
        if (ev.size() != 4) begin
            bad++;
            $display("FAIL one_bit_count: got %0d events, want 4", ev.size());
        end
        for (int k = 0; k < ev.size() && k < 4; k++) begin
            total++;
            if (exp[k][5] ? ev[k] !== exp[k] : ev[k][5:4] !== exp[k][5:4]) begin
                bad++;
                $display("FAIL one_bit_ev%0d: got %h, want %h", k, ev[k], exp[k]);
            end
        end
        for (int k = 1; k < ev_cyc.size(); k++) if (ev_cyc[k] == ev_cyc[k-1] + 1) adj++;
        total++;
        if (adj != 0) begin
            bad++;
            $display("FAIL one_bit_no_adjacent_ce: got %0d adjacent pairs, want 0", adj);
        end
    endtask

    task automatic test_align;
        logic [5:0] exp [2] = '{{2'b10, 4'hA}, {2'b00, 4'h0}};
        q.push_back(1'b1);
        push(G_I); push(G_I); push(G_J); push(G_K);
        push(DAT[10]); push(G_T); push(G_R); push(G_I); push(G_I);
        run(2);
        total++;
        if (ev.size() != 2) begin
            bad++;
            $display("FAIL align_count: got %0d events, want 2", ev.size());
        end
        for (int k = 0; k < ev.size() && k < 2; k++) begin
            total++;
            if (exp[k][5] ? ev[k] !== exp[k] : ev[k][5:4] !== exp[k][5:4]) begin
                bad++;
                $display("FAIL align_ev%0d: got %h, want %h", k, ev[k], exp[k]);
            end
        end
    endtask

    task automatic test_false_carrier;
        logic [5:0] exp [3] = '{{2'b01, 4'hE}, {2'b10, 4'h0}, {2'b00, 4'h0}};
        push(G_I); push(G_I); push(5'b11100); push(5'b11111);
        push(G_I); push(G_I); push(G_J); push(G_K);
        push(DAT[0]); push(G_T); push(G_R); push(G_I); push(G_I);
        run(2);
        total++;
        if (ev.size() != 3) begin
            bad++;
            $display("FAIL fc_count: got %0d events, want 3", ev.size());
        end
        for (int k = 0; k < ev.size() && k < 3; k++) begin
            total++;
            if (exp[k][5] ? ev[k] !== exp[k] : ev[k][5:4] !== exp[k][5:4]) begin
                bad++;
                $display("FAIL fc_ev%0d: got %h, want %h", k, ev[k], exp[k]);
            end
        end
        if (ev.size() > 0) begin
            total++;
            if (ev[0][3:0] !== 4'hE || ev_fc[0] !== 1'b1) begin
                bad++;
                $display("FAIL fc_first: got data=%h pulse=%b, want E 1", ev[0][3:0], ev_fc[0]);
            end
        end
        total++;
        if (fc_cnt != 1) begin
            bad++;
            $display("FAIL fc_pulses: got %0d, want 1", fc_cnt);
        end
    endtask

    task automatic test_bad_group;
        logic [5:0] exp [5] = '{{2'b10, 4'h3}, {2'b11, 4'h0}, {2'b01, 4'h0}, {2'b10, 4'h9}, {2'b00, 4'h0}};
        push(G_I); push(G_I); push(G_J); push(G_K);
        push(DAT[3]); push(G_H); push(G_I); push(G_I); push(G_I);
        push(G_J); push(G_K); push(DAT[9]); push(G_T); push(G_R); push(G_I); push(G_I);
        run(2);
        total++;
        if (ev.size() != 5) begin
            bad++;
            $display("FAIL badgrp_count: got %0d events, want 5", ev.size());
        end
        for (int k = 0; k < ev.size() && k < 5; k++) begin
            total++;
            if (exp[k][5] ? ev[k] !== exp[k] : ev[k][5:4] !== exp[k][5:4]) begin
                bad++;
                $display("FAIL badgrp_ev%0d: got %h, want %h", k, ev[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        push(G_I); push(G_I); push(G_J); push(G_K); push(DAT[7]);
        run(2);
        total++;
        if (ev.size() != 1 || ev[0] !== {2'b10, 4'h7}) begin
            bad++;
            $display("FAIL rstmid_pre: got %0d events first=%h, want 1 event 27", ev.size(), ev.size() ? ev[0] : 6'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({rx_ce, rx_data, rx_dv, rx_er, false_carrier} !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_async: got %b, want 00000000", {rx_ce, rx_data, rx_dv, rx_er, false_carrier});
        end
        @(negedge clk);
        rst = 1'b0;
        push(DAT[7]); push(G_I); push(DAT[0]); push(G_I); push(G_I);
        run(2);
        total++;
        if (ev.size() != 0 || fc_cnt != 0) begin
            bad++;
            $display("FAIL rstmid_quiet: got %0d events %0d pulses, want 0 0", ev.size(), fc_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_bit();
        test_one_bit_stall();
        test_align();
        test_false_carrier();
        test_bad_group();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
